// File: rtl/axi_cfg_slave_pkg.sv
// Shared constants and types for the AXI4 configuration responder.
package axi_cfg_slave_pkg;

    localparam logic [1:0] AXI_RESP_OKAY_C   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR_C = 2'b10;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_t;

endpackage

// File: rtl/axi_cfg_slave_rd.sv
// Read side of the config responder: AR capture, incrementing burst walk, R channel.
// state    | meaning
// RD_IDLE  | arready high, waiting for an AR handshake
// RD_BURST | rvalid high, presenting beats until the rlast beat is accepted
module axi_cfg_slave_rd
    import axi_cfg_slave_pkg::*;
#(
    parameter int AXI4_ID_WIDTH_P   = 2,
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = AXI4_DATA_WIDTH_P / 8,
    parameter int NR_OF_REGS_P      = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] cfg_registers,
    input  logic [AXI4_ID_WIDTH_P-1:0]                arid,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready
);

    localparam int IDX_SHIFT_C = $clog2(AXI4_STRB_WIDTH_P);

    rd_state_t                      state_q, state_d;
    logic [AXI4_ADDR_WIDTH_P-1:0]   idx_q, idx_d;
    logic [7:0]                     cnt_q, cnt_d;
    logic [AXI4_ID_WIDTH_P-1:0]     rid_q, rid_d;
    logic [AXI4_DATA_WIDTH_P-1:0]   rdata_q, rdata_d;
    logic [1:0]                     rresp_q, rresp_d;
    logic                           rlast_q, rlast_d;
    logic                           rvalid_q, rvalid_d;
    logic                           arready_q, arready_d;

    // Out-of-range indices read as zero; the caller supplies the error response.
    function automatic logic [AXI4_DATA_WIDTH_P-1:0] reg_word(
        input logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] regs,
        input logic [AXI4_ADDR_WIDTH_P-1:0]              idx
    );
        logic [AXI4_DATA_WIDTH_P-1:0] w;
        w = '0;
        for (int i = 0; i < NR_OF_REGS_P; i++) begin
            if (idx == AXI4_ADDR_WIDTH_P'(i)) begin
                w = regs[i*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P];
            end
        end
        return w;
    endfunction

    function automatic logic [1:0] beat_resp(input logic [AXI4_ADDR_WIDTH_P-1:0] idx);
        return (idx < AXI4_ADDR_WIDTH_P'(NR_OF_REGS_P)) ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RD_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY_C;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rvalid_d = rvalid_q;
        unique case (state_q)
            RD_IDLE: begin
                if (arvalid && arready_q) begin
                    idx_d    = araddr >> IDX_SHIFT_C;
                    cnt_d    = arlen;
                    rid_d    = arid;
                    rdata_d  = reg_word(cfg_registers, idx_d);
                    rresp_d  = beat_resp(idx_d);
                    rlast_d  = (arlen == 8'd0);
                    rvalid_d = 1'b1;
                    state_d  = RD_BURST;
                end
            end
            RD_BURST: begin
                if (rvalid_q && rready) begin
                    if (cnt_q != 8'd0) begin
                        // Next beat samples the registers at this edge, so a beat
                        // already on the bus keeps its value across a write.
                        idx_d   = idx_q + AXI4_ADDR_WIDTH_P'(1);
                        cnt_d   = cnt_q - 8'd1;
                        rdata_d = reg_word(cfg_registers, idx_d);
                        rresp_d = beat_resp(idx_d);
                        rlast_d = (cnt_q == 8'd1);
                    end else begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = RD_IDLE;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase
        arready_d = (state_d == RD_IDLE);
    end

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;

endmodule

// File: rtl/axi_cfg_slave.sv
// AXI4 configuration responder: single-beat writes into a register array, burst reads
// through the read sub-module, with flat register contents and per-register write strobes.
module axi_cfg_slave
    import axi_cfg_slave_pkg::*;
#(
    parameter int AXI4_ID_WIDTH_P   = 2,
    parameter int AXI4_ADDR_WIDTH_P = 16,
    parameter int AXI4_DATA_WIDTH_P = 32,
    parameter int AXI4_STRB_WIDTH_P = AXI4_DATA_WIDTH_P / 8,
    parameter int NR_OF_REGS_P      = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [AXI4_ID_WIDTH_P-1:0]                awid,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              awaddr,
    input  logic                                      awvalid,
    output logic                                      awready,
    input  logic [AXI4_DATA_WIDTH_P-1:0]              wdata,
    input  logic [AXI4_STRB_WIDTH_P-1:0]              wstrb,
    input  logic                                      wlast,
    input  logic                                      wvalid,
    output logic                                      wready,
    output logic [AXI4_ID_WIDTH_P-1:0]                bid,
    output logic [1:0]                                bresp,
    output logic                                      bvalid,
    input  logic                                      bready,
    input  logic [AXI4_ID_WIDTH_P-1:0]                arid,
    input  logic [AXI4_ADDR_WIDTH_P-1:0]              araddr,
    input  logic [7:0]                                arlen,
    input  logic                                      arvalid,
    output logic                                      arready,
    output logic [AXI4_ID_WIDTH_P-1:0]                rid,
    output logic [AXI4_DATA_WIDTH_P-1:0]              rdata,
    output logic [1:0]                                rresp,
    output logic                                      rlast,
    output logic                                      rvalid,
    input  logic                                      rready,
    output logic [NR_OF_REGS_P*AXI4_DATA_WIDTH_P-1:0] cfg_registers,
    output logic [NR_OF_REGS_P-1:0]                   cfg_wr_pulse
);

    localparam int IDX_SHIFT_C = $clog2(AXI4_STRB_WIDTH_P);
    localparam int BYTE_W_C    = AXI4_DATA_WIDTH_P / AXI4_STRB_WIDTH_P;

    logic [AXI4_DATA_WIDTH_P-1:0]  regs_q [NR_OF_REGS_P];
    logic [NR_OF_REGS_P-1:0]       wr_pulse_q;
    logic                          awready_q, wready_q, bvalid_q;
    logic                          aw_held_q, w_held_q;
    logic [AXI4_ID_WIDTH_P-1:0]    awid_q, bid_q;
    logic [AXI4_ADDR_WIDTH_P-1:0]  aw_idx_q;
    logic [AXI4_DATA_WIDTH_P-1:0]  wdata_q;
    logic [AXI4_STRB_WIDTH_P-1:0]  wstrb_q;
    logic [1:0]                    bresp_q;

    logic                          aw_hs, w_hs, b_hs, commit, c_ok;
    logic                          aw_held_d, w_held_d, bvalid_d;
    logic [AXI4_ID_WIDTH_P-1:0]    c_id;
    logic [AXI4_ADDR_WIDTH_P-1:0]  c_idx;
    logic [AXI4_DATA_WIDTH_P-1:0]  c_data;
    logic [AXI4_STRB_WIDTH_P-1:0]  c_strb;

    logic unused_wlast;
    assign unused_wlast = wlast;

    // The commit uses the live channel payload when that channel completes this cycle.
    always_comb begin
        aw_hs     = awvalid && awready_q;
        w_hs      = wvalid && wready_q;
        b_hs      = bvalid_q && bready;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        c_id      = aw_hs ? awid : awid_q;
        c_idx     = aw_hs ? (awaddr >> IDX_SHIFT_C) : aw_idx_q;
        c_data    = w_hs ? wdata : wdata_q;
        c_strb    = w_hs ? wstrb : wstrb_q;
        c_ok      = (c_idx < AXI4_ADDR_WIDTH_P'(NR_OF_REGS_P));
        aw_held_d = !commit && (aw_held_q || aw_hs);
        w_held_d  = !commit && (w_held_q || w_hs);
        bvalid_d  = commit || (bvalid_q && !b_hs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_OF_REGS_P; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awid_q     <= '0;
            bid_q      <= '0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= AXI_RESP_OKAY_C;
        end else begin
            wr_pulse_q <= '0;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            bvalid_q   <= bvalid_d;
            // Readies stay low from capture until the write response is taken.
            awready_q  <= !aw_held_d && !bvalid_d;
            wready_q   <= !w_held_d && !bvalid_d;
            if (aw_hs) begin
                awid_q   <= awid;
                aw_idx_q <= awaddr >> IDX_SHIFT_C;
            end
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                bid_q   <= c_id;
                bresp_q <= c_ok ? AXI_RESP_OKAY_C : AXI_RESP_SLVERR_C;
                for (int i = 0; i < NR_OF_REGS_P; i++) begin
                    if (c_ok && c_idx == AXI4_ADDR_WIDTH_P'(i)) begin
                        wr_pulse_q[i] <= 1'b1;
                        for (int b = 0; b < AXI4_STRB_WIDTH_P; b++) begin
                            if (c_strb[b]) begin
                                regs_q[i][b*BYTE_W_C +: BYTE_W_C] <= c_data[b*BYTE_W_C +: BYTE_W_C];
                            end
                        end
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NR_OF_REGS_P; g++) begin : g_flat
        assign cfg_registers[g*AXI4_DATA_WIDTH_P +: AXI4_DATA_WIDTH_P] = regs_q[g];
    end

    assign cfg_wr_pulse = wr_pulse_q;
    assign awready      = awready_q;
    assign wready       = wready_q;
    assign bvalid       = bvalid_q;
    assign bid          = bid_q;
    assign bresp        = bresp_q;

    axi_cfg_slave_rd #(
        .AXI4_ID_WIDTH_P   (AXI4_ID_WIDTH_P),
        .AXI4_ADDR_WIDTH_P (AXI4_ADDR_WIDTH_P),
        .AXI4_DATA_WIDTH_P (AXI4_DATA_WIDTH_P),
        .AXI4_STRB_WIDTH_P (AXI4_STRB_WIDTH_P),
        .NR_OF_REGS_P      (NR_OF_REGS_P)
    ) u_rd (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_registers (cfg_registers),
        .arid          (arid),
        .araddr        (araddr),
        .arlen         (arlen),
        .arvalid       (arvalid),
        .arready       (arready),
        .rid           (rid),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .rvalid        (rvalid),
        .rready        (rready)
    );

endmodule

// File: doc/axi_cfg_slave.md
Name: axi_cfg_slave

Overview:
- AXI4 configuration responder: the slave end of the team's AXI4 config interface.
- Holds NR_OF_REGS_P data-width configuration registers, written through AW/W/B and read back through AR/R.
- AR accepts incrementing bursts via arlen; writes are always single-beat.
- Exposes the register contents and per-register write strobes to the core logic.

Parameters:
- AXI4_ID_WIDTH_P, 2, width of awid/bid/arid/rid.
- AXI4_ADDR_WIDTH_P, 16, byte address width.
- AXI4_DATA_WIDTH_P, 32, data width; register width.
- AXI4_STRB_WIDTH_P, AXI4_DATA_WIDTH_P/8, write strobe width.
- NR_OF_REGS_P, 16, number of registers. Register index = addr >> log2(AXI4_STRB_WIDTH_P); low bits ignored.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- awid/awaddr/awvalid  in  ID/ADDR/1  write address channel.
- awready  out  1.
- wdata/wstrb/wlast/wvalid  in  DATA/STRB/1/1  write data channel; wlast ignored.
- wready  out  1.
- bid/bresp/bvalid  out  ID/2/1  write response channel.
- bready  in  1.
- arid/araddr/arlen/arvalid  in  ID/ADDR/8/1  read address channel.
- arready  out  1.
- rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1  read data channel.
- rready  in  1.
- cfg_registers  out  NR_OF_REGS_P*DATA  flat register contents; reg i at bits [i*DATA +: DATA].
- cfg_wr_pulse  out  NR_OF_REGS_P  one-cycle strobe on register i when it is written.

Behaviour:
- Reset:
  - All outputs and registers are 0 while rst_n is low, including all readies, bvalid, rvalid, cfg_registers and cfg_wr_pulse.
  - awready, wready and arready rise in the first cycle after rst_n deasserts.
- All outputs are registered. Valids, once asserted, hold with stable payload until their ready.
- Write path, AW and W are independent:
  - AW handshake latches awid and the register index; awready drops the next cycle.
  - W handshake latches wdata and wstrb; wready drops the next cycle.
  - Either order is accepted, and both in the same cycle.
- Write commit, at the edge where the second of AW/W is captured:
  - Register bytes with wstrb=1 are updated.
  - cfg_wr_pulse[idx] is high for exactly the following cycle; it pulses even when wstrb=0.
  - bvalid=1, with bid = latched awid.
  - Latency: register value and bvalid are both visible 1 cycle after the completing handshake.
- Write error: index >= NR_OF_REGS_P gives bresp=2'b10 (SLVERR), no register change and no pulse; otherwise bresp=2'b00.
- B handshake: bvalid drops next cycle; awready and wready both re-rise next cycle. No second write is accepted while B is pending.
- Read FSM:
  - RD_IDLE: arready=1.
  - AR handshake: latch arid, idx=araddr index, cnt=arlen; load rdata/rresp for idx; go to RD_BURST next cycle with rvalid=1, arready=0.
  - RD_BURST: rlast = (cnt==0).
    - R handshake with cnt!=0: idx++, cnt--, next beat's rdata loaded; rvalid stays 1 (back-to-back beats).
    - R handshake with cnt==0: rvalid=0, go to RD_IDLE; arready=1 next cycle.
- Per-beat read error: idx >= NR_OF_REGS_P gives rdata=0, rresp=SLVERR; the burst still completes with arlen+1 beats. idx does not wrap to 0 within a burst (idx width = ADDR bits).
- Read/write collision: a beat already loaded holds its value. A later beat of the same burst returns the post-write value.
- Read and write paths run concurrently with no arbitration.
- Reset mid-burst or mid-write aborts the transaction; everything returns to reset state and cfg_registers clear.

Decomposition:
- Package axi_cfg_slave_pkg:
  - AXI_RESP_OKAY_C=2'b00, AXI_RESP_SLVERR_C=2'b10.
  - typedef enum rd_state_t {RD_IDLE, RD_BURST}.
- One sub-module: axi_cfg_slave_rd (read FSM, burst counter, R channel), taking the flat register vector as input.
- The write path and register array stay in the top module.

Test Plan:
- Reset, then AW(awid=1, addr=0x0008) and W(0xDEADBEEF, strb=0xF) in the same cycle:
  - Expect cfg_registers reg2=0xDEADBEEF one cycle later and cfg_wr_pulse=0x0004 for one cycle.
  - Expect bvalid with bid=1, bresp=OKAY.
- W first (0x000000AA, strb=0x1), AW 3 cycles later (addr=0x0008, id=3):
  - Reg2=0xDEADBEAA.
  - With bready held low 4 cycles: bvalid held; awready and wready stay 0 until the cycle after the B handshake.
- AR(id=2, addr=0x0000, arlen=3) with rready=1:
  - 4 consecutive beats returning regs 0..3, rlast only on beat 4, rid=2, rresp=OKAY.
  - arready returns 1 after the last beat.
- Out-of-range access:
  - AR(addr=0x0038, arlen=3) with 16 regs: beats 0-1 OKAY (regs 14,15); beats 2-3 rdata=0, SLVERR.
  - Write to addr=0x0040: bresp=SLVERR, no pulse, registers unchanged.
- Random rready backpressure on an 8-beat burst: rdata/rlast stable while rvalid&&!rready; exactly 8 beats.
- Assert rst_n low mid-burst and mid-write: rvalid, bvalid and cfg_registers go 0 immediately; readies return 1 one cycle after release.
